seq_restoring_divider: RTL and testbench

- Parametrised multi-cycle restoring divider; next generation of the team's fixed 4-bit divider.
- Adds WIDTH generalisation, optional signed mode, divide-by-zero detection and valid/ready handshakes on both input and output.
- Sits between a requesting datapath and a result consumer.
- Computes one quotient bit per clock using the shift / subtract / restore algorithm.

---
 rtl/seq_restoring_divider.sv | 127 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional signed mode,
// divide-by-zero detection and valid/ready handshakes on request and result.
module seq_restoring_divider #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signed;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  // Operand magnitudes; the most negative value maps to 100..0, valid as unsigned
  assign w_signed  = SIGNED_EN && is_signed;
  assign w_dvd_neg = w_signed && dividend[WIDTH-1];
  assign w_dvs_neg = w_signed && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend) + ONE : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor) + ONE : divisor;

  // One shift/subtract/restore step; A never exceeds M so WIDTH+1 bits hold the sign
  assign w_a_sh  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff  = w_a_sh - {1'b0, r_m};
  assign w_a_nxt = w_diff[WIDTH] ? w_a_sh : w_diff;
  assign w_q_nxt = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};

  // Truncating division: remainder follows the dividend sign
  assign w_q_fin = r_neg_q ? (~w_q_nxt) + ONE : w_q_nxt;
  assign w_r_fin = r_neg_r ? (~w_a_nxt[WIDTH-1:0]) + ONE : w_a_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            start_ready <= 1'b0;
            busy        <= 1'b1;
            r_neg_q     <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r     <= w_dvd_neg;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_a         <= '0;
              r_q         <= w_dvd_mag;
              r_m         <= w_dvs_mag;
              r_cnt       <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              r_state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            quotient  <= w_q_fin;
            remainder <= w_r_fin;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8, signed mode enabled),
// directed cases plus randomized operands against an integer-arithmetic model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  // Reference: plain integer division (truncating), divide-by-zero convention
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int na, nb;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      if (s) begin
        na = int'($signed(a));
        nb = int'($signed(b));
      end else begin
        na = int'(a);
        nb = int'(b);
      end
      q  = W'(na / nb);
      r  = W'(na % nb);
      dz = 1'b0;
    end
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output bit to);
    int n = 0;
    to = 1'b0;
    while (!start_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!start_ready) begin
      to = 1'b1;
      return;
    end
    dividend = a; divisor = b; is_signed = s; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom); is_signed = 1'($urandom);
  endtask

  // Waits from just after the accept edge; lat counts further edges until out_valid
  task automatic wait_result(output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                             output int lat, output int sr_bad, output bit to);
    lat = 0; sr_bad = 0; to = 1'b0;
    while (!out_valid && lat < 40) begin
      if (start_ready) sr_bad++;
      dividend = W'($urandom); divisor = W'($urandom); is_signed = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) to = 1'b1;
    if (start_ready) sr_bad++;
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({out_valid, busy, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {out_valid, busy, div_by_zero});
    end
    checks++;
    if ({quotient, remainder} !== 16'h0000) begin
      errors++; $display("FAIL reset_data got=%h exp=0000", {quotient, remainder});
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++; $display("FAIL reset_start_ready got=%b exp=1", start_ready);
    end
  endtask

  logic [W-1:0] da [8] = '{8'd200, 8'hF9, 8'h07, 8'hF9, 8'h5A, 8'h5A, 8'h80, 8'h80};
  logic [W-1:0] db [8] = '{8'd7,   8'h02, 8'hFE, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF};
  logic         ds [8] = '{1'b0,   1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
  logic [W-1:0] dq [8] = '{8'h1C,  8'hFD, 8'hFD, 8'h7C, 8'hFF, 8'hFF, 8'h80, 8'h00};
  logic [W-1:0] dr [8] = '{8'h04,  8'hFF, 8'h01, 8'h01, 8'h5A, 8'h5A, 8'h00, 8'h80};
  logic         dd [8] = '{1'b0,   1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

  task automatic test_directed();
    logic [W-1:0] q, r;
    logic dz;
    int lat, sr_bad;
    bit to;
    for (int i = 0; i < 8; i++) begin
      out_ready = (i == 0);
      start_op(da[i], db[i], ds[i], to);
      wait_result(q, r, dz, lat, sr_bad, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL dir%0d_timeout got=no_out_valid exp=out_valid", i);
      end
      checks++;
      if (q !== dq[i] || r !== dr[i]) begin
        errors++; $display("FAIL dir%0d_result got=q%h r%h exp=q%h r%h", i, q, r, dq[i], dr[i]);
      end
      checks++;
      if (dz !== dd[i]) begin
        errors++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, dz, dd[i]);
      end
      checks++;
      if (lat !== (dd[i] ? 0 : W)) begin
        errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, dd[i] ? 0 : W);
      end
      checks++;
      if (sr_bad !== 0) begin
        errors++; $display("FAIL dir%0d_start_ready_busy got=%0d exp=0", i, sr_bad);
      end
      drain();
      checks++;
      if ({out_valid, busy, start_ready} !== 3'b001) begin
        errors++; $display("FAIL dir%0d_return_idle got=%b exp=001", i, {out_valid, busy, start_ready});
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er;
    logic s, dz, edz;
    int lat, sr_bad;
    bit to;
    for (int i = 0; i < 80; i++) begin
      a = W'($urandom);
      b = ($urandom_range(7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(5) == 0) a = 8'h80;
      s = 1'($urandom);
      model(a, b, s, eq, er, edz);
      start_op(a, b, s, to);
      wait_result(q, r, dz, lat, sr_bad, to);
      checks++;
      if (to || q !== eq || r !== er || dz !== edz) begin
        errors++;
        $display("FAIL rnd%0d %h/%h s=%b got=q%h r%h z%b exp=q%h r%h z%b",
                 i, a, b, s, q, r, dz, eq, er, edz);
      end
      checks++;
      if (lat !== (edz ? 0 : W) || sr_bad !== 0) begin
        errors++; $display("FAIL rnd%0d_timing got=lat%0d sr%0d exp=lat%0d sr0", i, lat, sr_bad, edz ? 0 : W);
      end
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q, r;
    logic dz;
    int lat, sr_bad, bad;
    bit to;
    start_op(8'd100, 8'd7, 1'b0, to);
    wait_result(q, r, dz, lat, sr_bad, to);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start_valid = 1'b1; dividend = W'($urandom); divisor = W'($urandom);
      @(posedge clk); #1;
      if (!out_valid || start_ready || quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero)
        bad++;
    end
    start_valid = 1'b0;
    checks++;
    if (to || bad !== 0) begin
      errors++; $display("FAIL backpressure_hold got=%0d_bad_cycles exp=0", bad);
    end
    drain();
    checks++;
    if ({out_valid, busy, start_ready} !== 3'b001) begin
      errors++; $display("FAIL backpressure_release got=%b exp=001", {out_valid, busy, start_ready});
    end
    dividend = 8'd9; divisor = 8'd3; is_signed = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    checks++;
    if ({busy, start_ready} !== 2'b10) begin
      errors++; $display("FAIL backpressure_next_accept got=%b exp=10", {busy, start_ready});
    end
    wait_result(q, r, dz, lat, sr_bad, to);
    checks++;
    if (to || q !== 8'd3 || r !== 8'd0 || lat !== W) begin
      errors++; $display("FAIL backpressure_next_result got=q%h r%h lat%0d exp=q03 r00 lat%0d", q, r, lat, W);
    end
    drain();
  endtask

  task automatic test_reset_midcalc();
    logic [W-1:0] q, r;
    logic dz;
    int lat, sr_bad, seen;
    bit to;
    start_op(8'd200, 8'd7, 1'b0, to);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({out_valid, busy, div_by_zero, start_ready} !== 4'b0001 || {quotient, remainder} !== 16'h0) begin
      errors++;
      $display("FAIL midcalc_reset got=%b q%h r%h exp=0001 q00 r00",
               {out_valid, busy, div_by_zero, start_ready}, quotient, remainder);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midcalc_discard got=%0d exp=0", seen);
    end
    start_op(8'd100, 8'd10, 1'b0, to);
    wait_result(q, r, dz, lat, sr_bad, to);
    checks++;
    if (to || q !== 8'd10 || r !== 8'd0 || dz !== 1'b0 || lat !== W) begin
      errors++; $display("FAIL midcalc_after got=q%h r%h z%b lat%0d exp=q0a r00 z0 lat%0d", q, r, dz, lat, W);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midcalc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
